// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the register file writeback controller
//
// Purpose: register file geometry, the queued writeback entry type and the
//          architectural zero register address.
// Contents: XLEN, AW, WB_DEPTH, wb_entry_t, REG_ZERO.

package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-write/1-read in-order writeback FIFO
//
// Purpose: holds pending register writes. Up to two entries are pushed per
//          cycle (wr0 is older than wr1) and one is popped from the head.
//          The contents are exposed in age order for the forwarding search.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr0_en_i/entry_i  first (older) push; must be set whenever wr1_en_i is
//   wr1_en_i/entry_i  second (younger) push
//   rd_en_i           pop the head entry
//   head_o            current head entry
//   count_o           occupancy
//   age_entry_o[k]    entry k places behind the head (k=0 is the oldest)
//   age_valid_o[k]    entry k is occupied

module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr0_en_i,
    input  wb_entry_t       wr0_entry_i,
    input  logic            wr1_en_i,
    input  wb_entry_t       wr1_entry_i,
    input  logic            rd_en_i,
    output wb_entry_t       head_o,
    output logic [CW-1:0]   count_o,
    output wb_entry_t       age_entry_o [DEPTH],
    output logic [DEPTH-1:0] age_valid_o
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_nx;

    always_comb begin
        wr_ptr_nx = wr_ptr_q + PW'(1);
        wr_ptr_d  = wr_ptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
        rd_ptr_d  = rd_ptr_q + PW'(rd_en_i);
        count_d   = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr0_en_i) mem_q[wr_ptr_q]  <= wr0_entry_i;
        if (wr1_en_i) mem_q[wr_ptr_nx] <= wr1_entry_i;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry_o[k] = mem_q[rd_ptr_q + PW'(k)];
            age_valid_o[k] = CW'(k) < count_q;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - register file write port controller with forwarding
//
// Purpose: accepts ALU and load writebacks, queues them in order, drains one
//          register file write per cycle and forwards pending data to decode.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   alu_valid/ready/rd/data      ALU writeback request
//   mem_valid/ready/rd/data      load writeback request
//   A3, WD3, WE3                 register file write port (registered)
//   rs1, rs2                     decode read addresses
//   fwd1_hit/data, fwd2_hit/data newest pending value for rs1/rs2
//   count                        queue occupancy

module regfile_wb_ctrl #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    output logic [AW-1:0]            A3,
    output logic [XLEN-1:0]          WD3,
    output logic                     WE3,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    import rf_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    logic [CW-1:0]    count_w;
    wb_entry_t        head_w;
    wb_entry_t        age_entry_w [DEPTH];
    logic [DEPTH-1:0] age_valid_w;
    logic             mem_push, alu_push, pop;
    logic             wr0_en, wr1_en;
    wb_entry_t        wr0_entry, alu_entry, mem_entry;

    logic             we_q;
    logic [AW-1:0]    a3_q;
    logic [XLEN-1:0]  wd3_q;

    // Ready looks only at the registered count: a drain this cycle does not
    // free a slot for a push this cycle. With one free slot the load wins.
    assign mem_ready = count_w < DEPTH_C;
    assign alu_ready = (count_w <= DEPTH_M2) || (count_w == DEPTH_M1 && !mem_valid);

    // x0 requests still handshake but never enter the queue.
    assign mem_push  = mem_valid && mem_ready && (mem_rd != REG_ZERO);
    assign alu_push  = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    assign pop       = count_w != '0;

    assign mem_entry = '{rd: mem_rd, data: mem_data};
    assign alu_entry = '{rd: alu_rd, data: alu_data};

    // The load is the older instruction, so it takes the first slot.
    assign wr0_en    = mem_push || alu_push;
    assign wr0_entry = mem_push ? mem_entry : alu_entry;
    assign wr1_en    = mem_push && alu_push;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .wr0_en_i    (wr0_en),
        .wr0_entry_i (wr0_entry),
        .wr1_en_i    (wr1_en),
        .wr1_entry_i (alu_entry),
        .rd_en_i     (pop),
        .head_o      (head_w),
        .count_o     (count_w),
        .age_entry_o (age_entry_w),
        .age_valid_o (age_valid_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q  <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                a3_q  <= head_w.rd;
                wd3_q <= head_w.data;
            end
        end
    end

    // Forwarding: the output stage is the oldest pending write (it lands at
    // the end of this cycle), then queue entries from head to tail. Later
    // matches overwrite earlier ones so the youngest wins.
    logic [1:0][AW-1:0]   rs_a;
    logic [1:0]           hit_a;
    logic [1:0][XLEN-1:0] data_a;

    assign rs_a[0] = rs1;
    assign rs_a[1] = rs2;

    always_comb begin
        hit_a  = '0;
        data_a = '0;
        for (int p = 0; p < 2; p++) begin
            if (rs_a[p] != REG_ZERO) begin
                if (we_q && a3_q == rs_a[p]) begin
                    hit_a[p]  = 1'b1;
                    data_a[p] = wd3_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_valid_w[k] && age_entry_w[k].rd == rs_a[p]) begin
                        hit_a[p]  = 1'b1;
                        data_a[p] = age_entry_w[k].data;
                    end
                end
            end
        end
    end

    assign fwd1_hit  = hit_a[0];
    assign fwd1_data = data_a[0];
    assign fwd2_hit  = hit_a[1];
    assign fwd2_data = data_a[1];

    assign WE3   = we_q;
    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign count = count_w;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl

module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rs1, rs2, A3;
    logic [31:0] alu_data, mem_data, WD3, fwd1_data, fwd2_data;
    logic        WE3, fwd1_hit, fwd2_hit;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .A3        (A3),
        .WD3       (WD3),
        .WE3       (WE3),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        rs1 = '0; rs2 = '0;

        // Reset held with a request pending
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
        tick(); tick();
        check("rst_we3",   WE3,   0);
        check("rst_count", count, 0);
        check("rst_a3",    A3,    0);
        check("rst_wd3",   WD3,   0);
        idle_inputs();
        rst = 1'b1;
        tick();
        check("rst_count_after", count, 0);
        check("rst_alu_ready",   alu_ready, 1);
        check("rst_mem_ready",   mem_ready, 1);

        // Single write with forwarding
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; rs1 = 5'd5;
        #1;
        check("single_incoming_not_fwd", fwd1_hit, 0);
        tick();
        idle_inputs();
        #1;
        check("single_count1",   count,     1);
        check("single_we3_early", WE3,      0);
        check("single_fwd_hit",  fwd1_hit,  1);
        check("single_fwd_data", fwd1_data, 32'hDEAD_BEEF);
        tick();
        check("single_we3",      WE3,       1);
        check("single_a3",       A3,        5);
        check("single_wd3",      WD3,       32'hDEAD_BEEF);
        check("single_fwd_out_stage", fwd1_hit, 1);
        tick();
        check("single_we3_off",  WE3,       0);
        check("single_a3_hold",  A3,        5);
        check("single_fwd_miss", fwd1_hit,  0);
        check("single_fwd_zero", fwd1_data, 0);

        // Dual push ordering, mem first
        rs1 = '0; rs2 = 5'd3;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        tick();
        idle_inputs();
        #1;
        check("dual_count",    count,     2);
        check("dual_fwd_hit",  fwd2_hit,  1);
        check("dual_fwd_data", fwd2_data, 32'h22);
        tick();
        check("dual_wd3_first",  WD3,       32'h11);
        check("dual_we3_first",  WE3,       1);
        check("dual_fwd_young",  fwd2_data, 32'h22);
        tick();
        check("dual_wd3_second", WD3,       32'h22);
        check("dual_a3_second",  A3,        3);
        check("dual_count_end",  count,     0);
        tick();
        check("dual_we3_done",   WE3,       0);
        rs2 = '0;

        // Backpressure: two pushes per cycle against one pop
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hA1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
        tick();
        check("bp_count_a", count, 2);
        check("bp_we3_a",   WE3,   0);
        mem_rd = 5'd3; mem_data = 32'hB1;
        alu_rd = 5'd4; alu_data = 32'hB2;
        #1;
        check("bp_alu_ready_2", alu_ready, 1);
        tick();
        check("bp_count_b", count, 3);
        check("bp_wd3_b",   WD3,   32'hA1);
        mem_rd = 5'd5; mem_data = 32'hC1;
        alu_rd = 5'd6; alu_data = 32'hC2;
        #1;
        check("bp_mem_ready_3", mem_ready, 1);
        check("bp_alu_ready_3", alu_ready, 0);
        tick();
        check("bp_count_c", count, 3);
        check("bp_wd3_c",   WD3,   32'hA2);
        mem_valid = 1'b0;
        #1;
        check("bp_alu_ready_nomem", alu_ready, 1);
        tick();
        idle_inputs();
        check("bp_count_d", count, 3);
        check("bp_wd3_d",   WD3,   32'hB1);
        tick();
        check("bp_wd3_e",   WD3,   32'hB2);
        check("bp_count_e", count, 2);
        tick();
        check("bp_wd3_f",   WD3,   32'hC1);
        tick();
        check("bp_wd3_g",   WD3,   32'hC2);
        check("bp_a3_g",    A3,    6);
        check("bp_count_g", count, 0);
        tick();
        check("bp_we3_off", WE3,   0);

        // x0 write is swallowed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF; rs1 = 5'd0;
        #1;
        check("x0_ready", alu_ready, 1);
        tick();
        idle_inputs();
        check("x0_count",   count,    0);
        check("x0_fwd_hit", fwd1_hit, 0);
        tick();
        check("x0_we3",      WE3, 0);
        check("x0_wd3_hold", WD3, 32'hC2);

        // Ten back-to-back ALU writes across pointer wrap
        for (int i = 1; i <= 10; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h1000 + 32'(i);
            tick();
            if (i >= 2) begin
                check("wrap_we3", WE3, 1);
                check("wrap_a3",  A3,  32'(i - 1));
                check("wrap_wd3", WD3, 32'h1000 + 32'(i - 1));
            end
            check("wrap_count", count, 1);
        end
        idle_inputs();
        tick();
        check("wrap_we3_last", WE3, 1);
        check("wrap_a3_last",  A3,  10);
        check("wrap_wd3_last", WD3, 32'h100A);
        tick();
        check("wrap_we3_off",  WE3, 0);

        // Reset in the middle of a drain with three entries queued
        mem_valid = 1'b1; mem_rd = 5'd8;  mem_data = 32'h81;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h91;
        tick();
        mem_rd = 5'd10; mem_data = 32'h82;
        alu_rd = 5'd11; alu_data = 32'h92;
        tick();
        idle_inputs();
        check("mid_count_3", count, 3);
        check("mid_we3_on",  WE3,   1);
        rst = 1'b0;
        #1;
        check("mid_rst_we3",   WE3,   0);
        check("mid_rst_count", count, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_write", WE3, 0);
        end
        check("mid_count_end", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writer-side controller for the core's 32x32 register file write port (A3/WD3/WE3).
- Accepts writeback requests from two producers, the ALU path and the load path, each with a valid/ready handshake.
- Queues the requests in a small in-order FIFO and drains one write per cycle into the register file.
- Also provides read-side forwarding for the decode stage, so reads of registers with a pending write return the newest data.

Parameters:
- XLEN, 32, data width of register write data.
- AW, 5, register address width.
- DEPTH, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_rd  in  AW  load destination register.
- mem_data  in  XLEN  load data.
- A3  out  AW  register file write address.
- WD3  out  XLEN  register file write data.
- WE3  out  1  register file write enable.
- rs1  in  AW  decode read address 1.
- rs2  in  AW  decode read address 2.
- fwd1_hit  out  1  pending write to rs1 exists.
- fwd1_data  out  XLEN  newest pending data for rs1.
- fwd2_hit  out  1  pending write to rs2 exists.
- fwd2_data  out  XLEN  newest pending data for rs2.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO is emptied and count=0.
  - WE3=0, A3=0, WD3=0.
  - Pending writes are discarded, including in the middle of a drain.
  - Deasserting reset is synchronous to clk.
- Handshake: a request transfers when valid&&ready on a rising edge. Producers hold rd/data stable while valid and not ready.
- Ready is computed from the registered count; there is no same-cycle credit from a drain.
  - mem_ready = (count < DEPTH).
  - alu_ready = (count ≤ DEPTH-2) || (count == DEPTH-1 && !mem_valid).
  - When only one slot is free, the load path wins.
- Ordering:
  - When both are accepted in the same cycle, the mem entry is enqueued first (older instruction) and the alu entry second.
  - The FIFO is strictly in order.
- x0 writes: a request with rd==0 completes its handshake but is not enqueued. It never produces WE3 and never produces a forwarding hit.
- Drain:
  - Each cycle with count>0 (pre-update), the head entry is popped into registered outputs: WE3=1, A3=rd, WD3=data for exactly one cycle.
  - Otherwise WE3=0. A3 and WD3 hold their last values.
  - Minimum latency: a request accepted at edge N produces WE3=1 in the cycle following edge N+1.
- Count update: count_next = count + pushes − pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}. Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - Searches all valid FIFO entries plus the output stage while WE3=1. The output stage is included because the register file write lands only at the end of that cycle.
  - The youngest match wins.
  - rs==0 gives hit=0.
  - Same-cycle incoming requests are not searched.
  - On a miss, fwd*_data=0.
- count never exceeds DEPTH. The pops≤1 rule and the push gating guarantee this; an assertion checks it.

Decomposition:
- Shared package `rf_pkg`:
  - XLEN and AW constants.
  - typedef wb_entry_t {logic [AW-1:0] rd; logic [XLEN-1:0] data;}.
  - REG_ZERO constant.
- One natural sub-module, `wb_fifo`: a 2-write/1-read in-order FIFO that exposes its entries and valid bits for the forwarding search.
- The forwarding search stays in the top level.

Test Plan:
- Reset: hold rst=0 with alu_valid=1 → WE3=0, count=0, readies high after release. Asserting rst mid-drain with count=3 → WE3=0 and count=0 immediately, with no further writes.
- Single write: accept alu rd=5, data=0xDEADBEEF at edge N → WE3=1, A3=5, WD3=0xDEADBEEF in the cycle after edge N+1. With rs1=5 in the cycle before that write, fwd1_hit=1 and fwd1_data=0xDEADBEEF.
- Dual push ordering: same cycle mem rd=3/0x11 and alu rd=3/0x22 → WE3 sequence is 0x11 then 0x22. While both are pending, rs2=3 gives fwd2_data=0x22.
- Full/backpressure: with no drain opportunity, fill to count=3 (DEPTH=4); then mem_valid and alu_valid together → mem accepted, alu_ready=0. The next cycle alu_ready follows the rule and count never exceeds 4.
- x0: alu rd=0, data=0xFFFFFFFF accepted → count unchanged, no WE3, rs1=0 gives fwd1_hit=0.
- Wrap-around: stream 10 back-to-back alu writes rd=1..10 → WE3 is high for 10 consecutive cycles with A3 = 1..10 in order and WD3 matching.
